// File: rtl/array_os_pkg.sv
// Shared types and sizing helpers for the output-stationary bit-serial array.
package array_os_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_e;

    // Steps needed after the last operand so it reaches the far corner PE.
    function automatic int flush_steps(input int height, input int width);
        return height + width - 2;
    endfunction

    function automatic int step_cnt_w(input int kwidth, input int height, input int width);
        int fw;
        fw = $clog2(height + width);
        return ((kwidth > fw) ? kwidth : fw) + 1;
    endfunction

endpackage

// File: rtl/pe_bs_os.sv
// One output-stationary PE: operand forwarding registers, bit-serial MAC on the
// weight bits (LSB first), and the accumulator that doubles as a drain shift stage.
module pe_bs_os #(
    parameter int IWIDTH = 16,
    parameter int OWIDTH = 32,
    parameter int BW     = $clog2(IWIDTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     adv,
    input  logic                     mac_en,
    input  logic [BW-1:0]            bidx,
    input  logic                     is_signed,
    input  logic [IWIDTH-1:0]        ifm_in,
    input  logic [IWIDTH-1:0]        wght_in,
    output logic [IWIDTH-1:0]        ifm_q,
    output logic [IWIDTH-1:0]        wght_q,
    input  logic                     shift,
    input  logic signed [OWIDTH-1:0] acc_in,
    output logic signed [OWIDTH-1:0] acc
);

    logic [IWIDTH-1:0]        ifm_cur;
    logic [IWIDTH-1:0]        wght_cur;
    logic signed [OWIDTH-1:0] ext;
    logic signed [OWIDTH-1:0] term;

    // On the step-advance cycle the new operand is used directly, so bit 0 costs no extra cycle.
    assign ifm_cur  = adv ? ifm_in  : ifm_q;
    assign wght_cur = adv ? wght_in : wght_q;
    assign ext      = {{(OWIDTH-IWIDTH){is_signed & ifm_cur[IWIDTH-1]}}, ifm_cur};
    assign term     = ext << bidx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifm_q  <= '0;
            wght_q <= '0;
            acc    <= '0;
        end else if (clear) begin
            ifm_q  <= '0;
            wght_q <= '0;
            acc    <= '0;
        end else begin
            if (adv) begin
                ifm_q  <= ifm_in;
                wght_q <= wght_in;
            end
            if (mac_en) begin
                // Two's-complement weight: the MSB carries negative weight.
                if (wght_cur[bidx])
                    acc <= (is_signed && bidx == BW'(IWIDTH-1)) ? acc - term : acc + term;
            end else if (shift) begin
                acc <= acc_in;
            end
        end
    end

endmodule

// File: rtl/array_os_bs_seq.sv
// HEIGHTxWIDTH output-stationary bit-serial MAC array with its own tile sequencer:
// accepts K step vectors, skews them into the grid, flushes, then drains result rows.
module array_os_bs_seq
    import array_os_pkg::*;
#(
    parameter int HEIGHT = 12,
    parameter int WIDTH  = 14,
    parameter int IWIDTH = 16,
    parameter int OWIDTH = 32,
    parameter int KWIDTH = 10
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [KWIDTH-1:0]              k_len,
    input  logic                           is_signed,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [HEIGHT-1:0][IWIDTH-1:0]  ifm,
    input  logic [WIDTH-1:0][IWIDTH-1:0]   wght,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0][OWIDTH-1:0]   ofm,
    output logic                           busy,
    output logic                           done
);

    localparam int BW      = $clog2(IWIDTH);
    localparam int SW      = step_cnt_w(KWIDTH, HEIGHT, WIDTH);
    localparam int RW      = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int FLUSH_N = flush_steps(HEIGHT, WIDTH);

    state_e              state;
    logic [BW-1:0]       bcnt;
    logic [SW-1:0]       steps;
    logic [RW-1:0]       rows;
    logic [KWIDTH-1:0]   k_q;
    logic                sgn_q;
    logic                adv, mac_en, clear, shift, last_bit;

    logic [IWIDTH-1:0]        ifm_edge  [HEIGHT];
    logic [IWIDTH-1:0]        wght_edge [WIDTH];
    logic [IWIDTH-1:0]        ifm_g     [HEIGHT][WIDTH];
    logic [IWIDTH-1:0]        wght_g    [HEIGHT][WIDTH];
    logic signed [OWIDTH-1:0] acc_g     [HEIGHT][WIDTH];

    assign last_bit  = (bcnt == BW'(IWIDTH-1));
    assign adv       = (bcnt == '0) && ((state == LOAD && in_valid) || state == FLUSH);
    assign mac_en    = (state == LOAD || state == FLUSH) && (bcnt != '0 || adv);
    assign clear     = (state == IDLE) && start;
    assign shift     = (state == DRAIN) && out_ready;
    assign in_ready  = (state == LOAD) && (bcnt == '0);
    assign out_valid = (state == DRAIN);
    assign busy      = (state != IDLE);

    always_comb begin
        for (int w = 0; w < WIDTH; w++)
            ofm[w] = (state == DRAIN) ? OWIDTH'(acc_g[0][w]) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            bcnt  <= '0;
            steps <= '0;
            rows  <= '0;
            k_q   <= '0;
            sgn_q <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        k_q   <= k_len;
                        sgn_q <= is_signed;
                        bcnt  <= '0;
                        steps <= '0;
                        rows  <= '0;
                        state <= (k_len == '0) ? DRAIN : LOAD;
                    end
                end
                LOAD, FLUSH: begin
                    if (mac_en)
                        bcnt <= last_bit ? '0 : bcnt + 1'b1;
                    if (adv)
                        steps <= steps + 1'b1;
                    if (state == LOAD && last_bit && steps == SW'(k_q)) begin
                        steps <= '0;
                        state <= (FLUSH_N == 0) ? DRAIN : FLUSH;
                    end else if (state == FLUSH && last_bit && steps == SW'(FLUSH_N)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (rows == RW'(HEIGHT-1)) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            rows <= rows + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Edge skew: row h / column w see their operand h / w steps late; zeros during flush.
    for (genvar h = 0; h < HEIGHT; h++) begin : g_iskew
        logic [IWIDTH-1:0] src;
        assign src = (state == LOAD) ? ifm[h] : '0;
        if (h == 0) begin : g_direct
            assign ifm_edge[h] = src;
        end else begin : g_line
            logic [IWIDTH-1:0] line [h];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n || clear) begin
                    for (int i = 0; i < h; i++) line[i] <= '0;
                end else if (adv) begin
                    line[0] <= src;
                    for (int i = 1; i < h; i++) line[i] <= line[i-1];
                end
            end
            assign ifm_edge[h] = line[h-1];
        end
    end

    for (genvar w = 0; w < WIDTH; w++) begin : g_wskew
        logic [IWIDTH-1:0] src;
        assign src = (state == LOAD) ? wght[w] : '0;
        if (w == 0) begin : g_direct
            assign wght_edge[w] = src;
        end else begin : g_line
            logic [IWIDTH-1:0] line [w];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n || clear) begin
                    for (int i = 0; i < w; i++) line[i] <= '0;
                end else if (adv) begin
                    line[0] <= src;
                    for (int i = 1; i < w; i++) line[i] <= line[i-1];
                end
            end
            assign wght_edge[w] = line[w-1];
        end
    end

    for (genvar h = 0; h < HEIGHT; h++) begin : g_row
        for (genvar w = 0; w < WIDTH; w++) begin : g_col
            logic [IWIDTH-1:0]        ifm_src, wght_src;
            logic signed [OWIDTH-1:0] acc_src;
            assign ifm_src  = (w == 0) ? ifm_edge[h]  : ifm_g[h][(w == 0) ? 0 : w-1];
            assign wght_src = (h == 0) ? wght_edge[w] : wght_g[(h == 0) ? 0 : h-1][w];
            assign acc_src  = (h == HEIGHT-1) ? '0 : acc_g[(h == HEIGHT-1) ? h : h+1][w];

            pe_bs_os #(.IWIDTH(IWIDTH), .OWIDTH(OWIDTH), .BW(BW)) u_pe (
                .clk       (clk),
                .rst_n     (rst_n),
                .clear     (clear),
                .adv       (adv),
                .mac_en    (mac_en),
                .bidx      (bcnt),
                .is_signed (sgn_q),
                .ifm_in    (ifm_src),
                .wght_in   (wght_src),
                .ifm_q     (ifm_g[h][w]),
                .wght_q    (wght_g[h][w]),
                .shift     (shift),
                .acc_in    (acc_src),
                .acc       (acc_g[h][w])
            );
        end
    end

endmodule

// File: tb/tb_array_os_bs_seq.sv
// Bench for array_os_bs_seq: table vectors, randomized tiles against a plain
// arithmetic dot-product model, and hand sequences for reset/backpressure/K=0.
module tb_array_os_bs_seq;

    localparam int H  = 2;
    localparam int W  = 3;
    localparam int IW = 8;
    localparam int OW = 24;
    localparam int KW = 10;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   start;
    logic [KW-1:0]          k_len;
    logic                   is_signed;
    logic                   in_valid;
    logic                   in_ready;
    logic [H-1:0][IW-1:0]   ifm;
    logic [W-1:0][IW-1:0]   wght;
    logic                   out_valid;
    logic                   out_ready;
    logic [W-1:0][OW-1:0]   ofm;
    logic                   busy;
    logic                   done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [H-1:0][IW-1:0] st_ifm  [64];
    logic [W-1:0][IW-1:0] st_wght [64];
    logic [W-1:0][OW-1:0] exp_row [H];

    typedef struct {
        int                   k;
        bit                   sgn;
        logic [H-1:0][IW-1:0] i0, i1;
        logic [W-1:0][IW-1:0] w0, w1;
        logic [W-1:0][OW-1:0] r0, r1;
    } vec_t;
    vec_t tbl [4];

    array_os_bs_seq #(.HEIGHT(H), .WIDTH(W), .IWIDTH(IW), .OWIDTH(OW), .KWIDTH(KW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .is_signed(is_signed),
        .in_valid(in_valid), .in_ready(in_ready), .ifm(ifm), .wght(wght),
        .out_valid(out_valid), .out_ready(out_ready), .ofm(ofm), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, expv, cyc);
        end
    endtask

    function automatic logic [H-1:0][IW-1:0] mk_i(input int a, input int b);
        logic [H-1:0][IW-1:0] v;
        v[0] = IW'(a); v[1] = IW'(b);
        return v;
    endfunction

    function automatic logic [W-1:0][IW-1:0] mk_w(input int a, input int b, input int c);
        logic [W-1:0][IW-1:0] v;
        v[0] = IW'(a); v[1] = IW'(b); v[2] = IW'(c);
        return v;
    endfunction

    function automatic logic [W-1:0][OW-1:0] mk_r(input int a, input int b, input int c);
        logic [W-1:0][OW-1:0] v;
        v[0] = OW'(a); v[1] = OW'(b); v[2] = OW'(c);
        return v;
    endfunction

    // Reference: plain dot products over the K stored steps, wrapped to OW bits.
    task automatic model(input int k, input bit sgn);
        longint acc, a, b;
        for (int h = 0; h < H; h++)
            for (int w = 0; w < W; w++) begin
                acc = 0;
                for (int s = 0; s < k; s++) begin
                    a = sgn ? longint'($signed(st_ifm[s][h]))  : longint'(st_ifm[s][h]);
                    b = sgn ? longint'($signed(st_wght[s][w])) : longint'(st_wght[s][w]);
                    acc += a * b;
                end
                exp_row[h][w] = acc[OW-1:0];
            end
    endtask

    task automatic run_tile(input int k, input bit sgn, input bit bp, input string tag);
        int c0, guard;
        @(posedge clk); #1;
        start = 1'b1; k_len = KW'(k); is_signed = sgn; out_ready = 1'b0;
        if (k > 0) begin
            ifm = st_ifm[0]; wght = st_wght[0]; in_valid = 1'b1;
        end
        c0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int s = 0; s < k; s++) begin
            ifm = st_ifm[s]; wght = st_wght[s];
            in_valid = !(bp && (s % 2 == 1));
            guard = 0;
            @(negedge clk);
            while (!in_ready && guard < 200) begin guard++; @(negedge clk); end
            if (guard >= 200) chk({tag, " ready_timeout"}, 0, 1);
            if (bp && (s % 2 == 1)) begin
                repeat (3) @(negedge clk);
                chk({tag, " stall_ready"}, in_ready, 1'b1);
                in_valid = 1'b1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 2000) begin guard++; @(negedge clk); end
        if (guard >= 2000) chk({tag, " out_timeout"}, 0, 1);
        if (k > 0 && !bp)
            chk({tag, " latency"}, cyc - c0, (k + H + W - 2) * IW + 1);
        for (int r = 0; r < H; r++) begin
            if (r > 0) @(negedge clk);
            if (bp && r == 1) begin
                for (int i = 0; i < 5; i++) begin
                    chk({tag, " hold_ofm"}, ofm, exp_row[r]);
                    chk({tag, " hold_valid"}, out_valid, 1'b1);
                    @(negedge clk);
                end
            end
            out_ready = 1'b1;
            chk({tag, " out_valid"}, out_valid, 1'b1);
            chk({tag, $sformatf(" row%0d", r)}, ofm, exp_row[r]);
            chk({tag, " done_early"}, done, 1'b0);
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        @(negedge clk);
        chk({tag, " done"}, done, 1'b1);
        chk({tag, " idle_busy"}, busy, 1'b0);
        chk({tag, " idle_ofm"}, ofm, '0);
        @(negedge clk);
        chk({tag, " done_pulse"}, done, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; k_len = '0; is_signed = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; ifm = '0; wght = '0;

        tbl[0] = '{k: 2, sgn: 1'b0, i0: mk_i(1, 2), i1: mk_i(3, 4),
                   w0: mk_w(1, 2, 3), w1: mk_w(5, 6, 7),
                   r0: mk_r(16, 20, 24), r1: mk_r(22, 28, 34)};
        tbl[1] = '{k: 1, sgn: 1'b1, i0: mk_i(-3, 127), i1: '0,
                   w0: mk_w(-128, 2, -1), w1: '0,
                   r0: mk_r(384, -6, 3), r1: mk_r(-16256, 254, -127)};
        tbl[2] = '{k: 1, sgn: 1'b0, i0: mk_i(-3, 127), i1: '0,
                   w0: mk_w(-128, 2, -1), w1: '0,
                   r0: mk_r(32384, 506, 64515), r1: mk_r(16256, 254, 32385)};
        tbl[3] = '{k: 2, sgn: 1'b1, i0: mk_i(-1, -128), i1: mk_i(5, -7),
                   w0: mk_w(-128, -128, 3), w1: mk_w(1, -1, 100),
                   r0: mk_r(133, 123, 497), r1: mk_r(16377, 16391, -1084)};

        // Start pulsed while held in reset must do nothing.
        repeat (2) @(posedge clk);
        #1 start = 1'b1; k_len = 10'd2;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst busy", busy, 1'b0);
        chk("rst in_ready", in_ready, 1'b0);
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst ofm", ofm, '0);
        chk("rst done", done, 1'b0);
        start = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle busy", busy, 1'b0);
        chk("idle in_ready", in_ready, 1'b0);

        for (int t = 0; t < 4; t++) begin
            st_ifm[0] = tbl[t].i0; st_ifm[1] = tbl[t].i1;
            st_wght[0] = tbl[t].w0; st_wght[1] = tbl[t].w1;
            exp_row[0] = tbl[t].r0; exp_row[1] = tbl[t].r1;
            run_tile(tbl[t].k, tbl[t].sgn, 1'b0, $sformatf("tbl%0d", t));
        end

        // Backpressure on the first table vector.
        st_ifm[0] = tbl[0].i0; st_ifm[1] = tbl[0].i1;
        st_wght[0] = tbl[0].w0; st_wght[1] = tbl[0].w1;
        exp_row[0] = tbl[0].r0; exp_row[1] = tbl[0].r1;
        run_tile(2, 1'b0, 1'b1, "bp_tbl0");

        // K=0: straight to DRAIN with zeros; a start during DRAIN is ignored.
        @(posedge clk); #1 start = 1'b1; k_len = '0;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("k0 out_valid", out_valid, 1'b1);
        chk("k0 row0", ofm, '0);
        @(posedge clk); #1 start = 1'b1; k_len = 10'd5;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("k0 ignore busy", busy, 1'b1);
        chk("k0 ignore in_ready", in_ready, 1'b0);
        chk("k0 ignore valid", out_valid, 1'b1);
        for (int r = 0; r < H; r++) begin
            out_ready = 1'b1;
            chk($sformatf("k0 drain row%0d", r), ofm, '0);
            @(posedge clk); #1 out_ready = 1'b0;
            @(negedge clk);
        end
        chk("k0 done", done, 1'b1);
        @(negedge clk);
        chk("k0 back idle", busy, 1'b0);

        // Randomized tiles against the model.
        for (int t = 0; t < 8; t++) begin
            int k;
            bit sgn;
            k   = (t == 7) ? 20 : $urandom_range(1, 8);
            sgn = $urandom_range(0, 1);
            for (int s = 0; s < k; s++) begin
                st_ifm[s]  = H*IW'($urandom);
                st_wght[s] = W*IW'($urandom);
            end
            model(k, sgn);
            run_tile(k, sgn, t[0], $sformatf("rnd%0d", t));
        end

        // Reset while flushing: abort, no done, next tile clean.
        @(posedge clk); #1;
        start = 1'b1; k_len = 10'd2; is_signed = 1'b1;
        ifm = mk_i(100, -100); wght = mk_w(77, -77, 55); in_valid = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2 * IW + 6) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("flush busy", busy, 1'b1);
        chk("flush in_ready", in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("abort busy", busy, 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("abort done", done, 1'b0);
            chk("abort valid", out_valid, 1'b0);
        end
        rst_n = 1'b1;
        for (int s = 0; s < 3; s++) begin
            st_ifm[s]  = H*IW'($urandom);
            st_wght[s] = W*IW'($urandom);
        end
        model(3, 1'b0);
        run_tile(3, 1'b0, 1'b0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1);
    end

endmodule
